// File: rtl/ph_host_port_pkg.sv
// ph_host_port_pkg: shared Tube host-port state encoding, register addresses and status bit positions
package ph_host_port_pkg;
  typedef enum logic [1:0] {EMPTY = 2'd0, FETCH = 2'd1, FULL = 2'd2} state_t;
  localparam logic ADDR_STATUS = 1'b0;
  localparam logic ADDR_DATA   = 1'b1;
  localparam int DA  = 7;
  localparam int IE  = 6;
  localparam int IRQ = 0;
endpackage

// File: rtl/ph_host_port_if.sv
// ph_host_port_if: host bus and upstream FIFO signals of the parasite-to-host data channel
interface ph_host_port_if;
  logic       h_cs_b;
  logic       h_addr;
  logic       h_rdnw;
  logic [7:0] h_din;
  logic [7:0] h_dout;
  logic [7:0] fifo_dout;
  logic       fifo_empty;
  logic       fifo_rd_en;
  logic       h_irq_b;
  logic       h_data_available;
  modport slave (
    input  h_cs_b, h_addr, h_rdnw, h_din, fifo_dout, fifo_empty,
    output h_dout, fifo_rd_en, h_irq_b, h_data_available
  );
  modport master (
    output h_cs_b, h_addr, h_rdnw, h_din, fifo_dout, fifo_empty,
    input  h_dout, fifo_rd_en, h_irq_b, h_data_available
  );
endinterface

// File: rtl/ph_host_port.sv
// ph_host_port: prefetches parasite-to-host FIFO bytes into a holding register and exposes data/status registers plus an interrupt to the host
module ph_host_port
  import ph_host_port_pkg::*;
#(
  parameter logic [7:0] IDLE_DATA   = 8'hAA,
  parameter logic       STATUS_FILL = 1'b0
) (
  input logic           h_phi2,
  input logic           h_rst_b,
  ph_host_port_if.slave bus
);
  state_t     state, state_d;
  logic [7:0] hold, status;
  logic       ie, ie_d, irq_b, rd_en, data_rd, stat_wr;
  logic       unused_din;
  assign data_rd    = ~bus.h_cs_b & (bus.h_addr == ADDR_DATA) & bus.h_rdnw;
  assign stat_wr    = ~bus.h_cs_b & (bus.h_addr == ADDR_STATUS) & ~bus.h_rdnw;
  assign ie_d       = stat_wr ? bus.h_din[IE] : ie;
  assign unused_din = ^{bus.h_din[7], bus.h_din[5:0]};
  always_comb begin
    state_d = state;
    rd_en   = 1'b0;
    case (state)
      EMPTY: begin
        rd_en   = ~bus.fifo_empty;
        state_d = bus.fifo_empty ? EMPTY : FETCH;
      end
      FETCH: state_d = FULL;
      FULL: if (data_rd) begin
        rd_en   = ~bus.fifo_empty;
        state_d = bus.fifo_empty ? EMPTY : FETCH;
      end
      default: state_d = EMPTY;
    endcase
  end
  // irq is computed from next-state values so it lines up with the FULL/ie register updates
  always_ff @(posedge h_phi2 or negedge h_rst_b) begin
    if (!h_rst_b) begin
      state <= EMPTY;
      hold  <= 8'h00;
      ie    <= 1'b0;
      irq_b <= 1'b1;
    end else begin
      state <= state_d;
      ie    <= ie_d;
      irq_b <= ~(ie_d & (state_d == FULL));
      if (state == FETCH) hold <= bus.fifo_dout;
    end
  end
  always_comb begin
    status      = {8{STATUS_FILL}};
    status[DA]  = state == FULL;
    status[IE]  = ie;
    status[IRQ] = ~irq_b;
  end
  assign bus.h_dout = bus.h_cs_b ? 8'h00
                    : bus.h_addr == ADDR_STATUS ? status
                    : state == FULL ? hold : IDLE_DATA;
  assign bus.fifo_rd_en       = rd_en;
  assign bus.h_irq_b          = irq_b;
  assign bus.h_data_available = state == FULL;
endmodule

// File: tb/tb_ph_host_port.sv
// tb_ph_host_port: directed stimulus with a FIFO stub, a per-cycle behavioural model compare and literal spot checks
module tb_ph_host_port;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] q[$];
  logic [7:0] got[$];
  int         checks = 0, errors = 0, rd_pulses = 0, p0;
  logic       rd_seen = 1'b0;
  logic       m_full = 1'b0, m_fetch = 1'b0, m_ie = 1'b0, m_irq_b = 1'b1;
  logic [7:0] m_hold = 8'h00;
  always #5 clk = ~clk;
  ph_host_port_if bus();
  ph_host_port dut (.h_phi2(clk), .h_rst_b(rst_n), .bus(bus));
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // FIFO stub: pop lands on fifo_dout just after the edge that saw rd_en
  task automatic cyc(input logic cs_b, input logic a, input logic rdnw, input logic [7:0] din);
    @(posedge clk);
    #1;
    if (rd_seen && q.size() > 0) bus.fifo_dout = q.pop_front();
    @(negedge clk);
    bus.fifo_empty = (q.size() == 0);
    bus.h_cs_b = cs_b;
    bus.h_addr = a;
    bus.h_rdnw = rdnw;
    bus.h_din  = din;
  endtask
  task automatic idle();
    cyc(1'b1, 1'b0, 1'b1, 8'h00);
  endtask
  task automatic rd(input logic a);
    cyc(1'b0, a, 1'b1, 8'h00);
  endtask
  task automatic wr(input logic [7:0] d);
    cyc(1'b0, 1'b0, 1'b0, d);
  endtask
  initial forever begin
    logic dr, sw, e_rd, n_full, n_ie;
    logic [7:0] e_dout;
    @(negedge clk);
    #4;
    dr = !bus.h_cs_b && bus.h_addr && bus.h_rdnw;
    sw = !bus.h_cs_b && !bus.h_addr && !bus.h_rdnw;
    if (!rst_n) begin
      m_full = 0; m_fetch = 0; m_hold = 8'h00; m_ie = 0; m_irq_b = 1;
    end
    e_rd   = rst_n && !bus.fifo_empty && !m_fetch && (!m_full || dr);
    e_dout = bus.h_cs_b ? 8'h00 : !bus.h_addr ? {m_full, m_ie, 5'b00000, !m_irq_b}
           : m_full ? m_hold : 8'hAA;
    chk("model fifo_rd_en", {7'b0, bus.fifo_rd_en}, {7'b0, e_rd});
    chk("model data_available", {7'b0, bus.h_data_available}, {7'b0, m_full});
    chk("model h_irq_b", {7'b0, bus.h_irq_b}, {7'b0, m_irq_b});
    if (bus.h_cs_b || bus.h_rdnw) chk("model h_dout", bus.h_dout, e_dout);
    rd_seen = bus.fifo_rd_en;
    if (bus.fifo_rd_en) rd_pulses++;
    if (rst_n) begin
      n_ie = sw ? bus.h_din[6] : m_ie;
      if (m_fetch) begin
        m_hold = bus.fifo_dout;
        n_full = 1;
      end else n_full = m_full && !dr;
      m_fetch = e_rd;
      m_full  = n_full;
      m_ie    = n_ie;
      m_irq_b = !(n_ie && n_full);
    end
  end
  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    bus.h_cs_b = 1; bus.h_addr = 0; bus.h_rdnw = 1; bus.h_din = 0;
    bus.fifo_dout = 0; bus.fifo_empty = 1;
    repeat (3) idle();
    rst_n = 1;
    idle();
    rd(0); #3 chk("powerup status", bus.h_dout, 8'h00);
    // single byte
    q.push_back(8'h5C);
    idle(); #3 chk("single rd_en on", {7'b0, bus.fifo_rd_en}, 8'h01);
    idle(); #3 chk("single rd_en off", {7'b0, bus.fifo_rd_en}, 8'h00);
    chk("single da in fetch", {7'b0, bus.h_data_available}, 8'h00);
    idle(); #3 chk("single da", {7'b0, bus.h_data_available}, 8'h01);
    rd(1); #3 chk("single data", bus.h_dout, 8'h5C);
    rd(1); #3 chk("single idle data", bus.h_dout, 8'hAA);
    // streaming with a read every second cycle
    p0 = rd_pulses;
    for (int i = 1; i <= 4; i++) q.push_back(8'(i));
    idle(); idle();
    for (int i = 0; i < 4; i++) begin
      rd(1); #3 got.push_back(bus.h_dout);
      idle();
    end
    for (int i = 0; i < 4; i++) chk("stream byte", got[i], 8'(i + 1));
    chk("stream pulses", 8'(rd_pulses - p0), 8'd4);
    // read while the byte is still in flight
    q.push_back(8'h9E);
    idle();
    rd(1); #3 chk("fetch read", bus.h_dout, 8'hAA);
    rd(1); #3 chk("after fetch read", bus.h_dout, 8'h9E);
    // interrupt
    wr(8'h40);
    q.push_back(8'h77);
    idle(); idle();
    rd(0); #3 chk("irq status", bus.h_dout, 8'hC1);
    chk("irq low", {7'b0, bus.h_irq_b}, 8'h00);
    rd(1); #3 chk("irq data", bus.h_dout, 8'h77);
    idle(); #3 chk("irq released by read", {7'b0, bus.h_irq_b}, 8'h01);
    q.push_back(8'h3D);
    idle(); idle();
    idle(); #3 chk("irq low again", {7'b0, bus.h_irq_b}, 8'h00);
    wr(8'h00);
    idle(); #3 chk("irq released by ie", {7'b0, bus.h_irq_b}, 8'h01);
    chk("still full", {7'b0, bus.h_data_available}, 8'h01);
    wr(8'h40);
    idle(); #3 chk("irq rearmed", {7'b0, bus.h_irq_b}, 8'h00);
    // asynchronous reset mid-cycle
    idle();
    #2 rst_n = 0;
    q.delete();
    #1 chk("reset irq", {7'b0, bus.h_irq_b}, 8'h01);
    chk("reset rd_en", {7'b0, bus.fifo_rd_en}, 8'h00);
    chk("reset da", {7'b0, bus.h_data_available}, 8'h00);
    idle();
    rst_n = 1;
    rd(0); #3 chk("reset status", bus.h_dout, 8'h00);
    // reset while a byte is in flight
    q.push_back(8'h4B);
    idle(); idle();
    #2 rst_n = 0;
    #1 chk("fetch reset da", {7'b0, bus.h_data_available}, 8'h00);
    idle();
    rst_n = 1;
    p0 = rd_pulses;
    rd(1); #3 chk("lost byte", bus.h_dout, 8'hAA);
    repeat (3) idle();
    #3 chk("no pop when empty", 8'(rd_pulses - p0), 8'd0);
    idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
